// File: rtl/data_mem_responder.sv
// Single-port word memory responder with a byte-addressed access port, one-cycle registered
// reads, misaligned/out-of-range error pulses, access counters and a backdoor init port.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           mem_en,
   input  logic                           mem_we,
   input  logic [31:0]                    mem_addr,
   input  logic [31:0]                    mem_wdata,
   output logic [31:0]                    mem_rdata,
   output logic                           rdata_valid,
   output logic                           err_misaligned,
   output logic                           err_range,
   output logic                           err_sticky,
   input  logic                           init_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx,
   input  logic [31:0]                    init_data,
   output logic [31:0]                    rd_count,
   output logic [31:0]                    wr_count
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   // 33 bits so that a window covering the whole 4 GiB space still compares correctly.
   localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;

   logic [31:0]      mem_array [DEPTH_WORDS];

   logic [31:0]      offset;
   logic [IDX_W-1:0] word_idx;
   logic             in_range;
   logic             misaligned;
   logic             rd_req;
   logic             wr_req;
   logic             wr_blocked;
   logic             wr_commit;
   logic             rd_counted;
   logic             flag_mis;
   logic             flag_rng;

   // Address decode and access qualification.
   always_comb begin
      offset     = mem_addr - ADDR_BASE;
      word_idx   = offset[IDX_W+1:2];
      // Addresses below the base wrap to huge offsets and land out of range here.
      in_range   = {1'b0, offset} < RANGE_BYTES;
      misaligned = |mem_addr[1:0];

      rd_req     = mem_en & ~mem_we;
      wr_req     = mem_en & mem_we;
      // A backdoor init wins over a same-cycle port write; the port write vanishes silently.
      wr_blocked = wr_req & init_en;
      wr_commit  = wr_req & in_range & ~misaligned & ~init_en & ~rst;
      rd_counted = rd_req & in_range;

      flag_mis   = mem_en & misaligned & ~wr_blocked;
      flag_rng   = mem_en & ~in_range & ~wr_blocked;
   end

   // Storage array: no reset, so contents survive rst; init has priority over port writes.
   always_ff @(posedge clk) begin
      if (init_en) begin
         mem_array[init_idx] <= init_data;
      end else if (wr_commit) begin
         mem_array[word_idx] <= mem_wdata;
      end
   end

   // Registered read data; holds its value unless a read completes, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rdata   <= '0;
         rdata_valid <= 1'b0;
      end else begin
         rdata_valid <= rd_req;
         if (rd_req) begin
            // Array read samples the pre-edge contents, so a same-cycle init is not visible.
            mem_rdata <= in_range ? mem_array[word_idx] : '0;
         end
      end
   end

   // Error pulses and the sticky summary, which rises together with the first pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_misaligned <= 1'b0;
         err_range      <= 1'b0;
         err_sticky     <= 1'b0;
      end else begin
         err_misaligned <= flag_mis;
         err_range      <= flag_rng;
         err_sticky     <= err_sticky | flag_mis | flag_rng;
      end
   end

   // Completed in-range access counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rd_counted) begin
            rd_count <= rd_count + 32'd1;
         end
         if (wr_commit) begin
            wr_count <= wr_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: each step drives one cycle of stimulus, a behavioural
// model pushes the expected post-edge outputs to a scoreboard, and the entry is popped and
// compared one time unit after the edge.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   typedef struct {
      logic [31:0] rdata;
      logic        valid;
      logic        emis;
      logic        erng;
      logic        sticky;
      logic [31:0] rdc;
      logic [31:0] wrc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        rdata_valid;
   logic        err_misaligned;
   logic        err_range;
   logic        err_sticky;
   logic        init_en;
   logic [9:0]  init_idx;
   logic [31:0] init_data;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   int tests = 0;
   int fails = 0;

   exp_t  sb[$];
   string tg[$];

   // Reference model state.
   logic [31:0] mm [DEPTH];
   logic [31:0] m_rdata  = '0;
   logic [31:0] m_rdc    = '0;
   logic [31:0] m_wrc    = '0;
   logic        m_sticky = 1'b0;

   data_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_BASE   (BASE)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .rdata_valid    (rdata_valid),
      .err_misaligned (err_misaligned),
      .err_range      (err_range),
      .err_sticky     (err_sticky),
      .init_en        (init_en),
      .init_idx       (init_idx),
      .init_data      (init_data),
      .rd_count       (rd_count),
      .wr_count       (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic en, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd, input logic ien,
                       input logic [9:0] iidx, input logic [31:0] idat);
      exp_t        e;
      exp_t        got;
      string       t;
      logic [31:0] off;
      logic [9:0]  idx;
      logic        inr;
      logic        mis;
      logic        blk;
      logic        wr_ok;
      rst       = r;
      mem_en    = en;
      mem_we    = we;
      mem_addr  = addr;
      mem_wdata = wd;
      init_en   = ien;
      init_idx  = iidx;
      init_data = idat;

      off = addr - BASE;
      idx = off[11:2];
      inr = (off < 32'(DEPTH * 4));
      mis = (addr[1:0] != 2'b00);
      blk = en & we & ien;
      wr_ok = en & we & inr & !mis & !ien;
      if (r) begin
         m_rdata  = '0;
         m_rdc    = '0;
         m_wrc    = '0;
         m_sticky = 1'b0;
         e.valid  = 1'b0;
         e.emis   = 1'b0;
         e.erng   = 1'b0;
         wr_ok    = 1'b0;
      end else begin
         e.valid = en & !we;
         if (en && !we) begin
            m_rdata = inr ? mm[idx] : 32'h0;
            if (inr) m_rdc = m_rdc + 1;
         end
         e.emis = en & mis & !blk;
         e.erng = en & !inr & !blk;
         m_sticky = m_sticky | e.emis | e.erng;
         if (wr_ok) m_wrc = m_wrc + 1;
      end
      // Array updates after the read so that a same-cycle read sees pre-edge contents.
      if (ien) mm[iidx] = idat;
      else if (wr_ok) mm[idx] = wd;
      e.rdata  = m_rdata;
      e.sticky = m_sticky;
      e.rdc    = m_rdc;
      e.wrc    = m_wrc;
      sb.push_back(e);
      tg.push_back(tag);

      @(posedge clk);
      #1;
      got = sb.pop_front();
      t   = tg.pop_front();
      chk({t, ".rdata_valid"}, {31'b0, rdata_valid}, {31'b0, got.valid});
      chk({t, ".mem_rdata"}, mem_rdata, got.rdata);
      chk({t, ".err_misaligned"}, {31'b0, err_misaligned}, {31'b0, got.emis});
      chk({t, ".err_range"}, {31'b0, err_range}, {31'b0, got.erng});
      chk({t, ".err_sticky"}, {31'b0, err_sticky}, {31'b0, got.sticky});
      chk({t, ".rd_count"}, rd_count, got.rdc);
      chk({t, ".wr_count"}, wr_count, got.wrc);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr);
      step(tag, 1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b0, 10'd0, 32'h0);
   endtask

   task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
      step(tag, 1'b0, 1'b1, 1'b1, addr, data, 1'b0, 10'd0, 32'h0);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 10'd0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      init_en = 1'b0; init_idx = '0; init_data = '0;
      #1;

      // Reset state, with backdoor preload honoured while rst is held.
      for (int i = 0; i < 16; i++) begin
         step("reset_preload", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 10'(i),
              32'hA500_0000 + 32'(i * 32'h0101));
      end

      // Preload word 5 and read it back at byte address 20.
      step("init5", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 10'd5, 32'hDEAD_BEEF);
      rd("rd_init5", BASE + 32'd20);

      // Write then read in the following cycle.
      wr("wr_0x10", 32'h10, 32'h1234_5678);
      rd("rd_0x10", 32'h10);

      // Misaligned write is dropped; misaligned read returns the containing word.
      wr("wr_misal", 32'h13, 32'hFFFF_0000);
      idle("idle_after_misal");
      rd("rd_misal", 32'h13);

      // Out of range reads: first word past the end, wrapped address, and both errors at once.
      rd("rd_oor", 32'd4096);
      rd("rd_oor_wrap", 32'hFFFF_FFFC);
      rd("rd_oor_misal", 32'd4097);
      wr("wr_oor", 32'd8192, 32'h5555_5555);

      // Back-to-back reads, then idle cycles holding the last data.
      rd("b2b_0", 32'h0);
      rd("b2b_4", 32'h4);
      rd("b2b_8", 32'h8);
      idle("hold_1");
      idle("hold_2");

      // Init beats a same-cycle port write without flagging errors.
      step("init_vs_wr", 1'b0, 1'b1, 1'b1, 32'h20, 32'h1111_1111, 1'b1, 10'd8, 32'h2222_2222);
      rd("rd_init_vs_wr", 32'h20);
      step("init_vs_badwr", 1'b0, 1'b1, 1'b1, 32'h5001, 32'h0, 1'b1, 10'd9, 32'h3333_3333);
      rd("rd_word9", 32'h24);

      // Same-cycle init and read of one word: read sees the old value.
      step("init_vs_rd", 1'b0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b1, 10'd10, 32'h4444_4444);
      rd("rd_word10_new", 32'h28);

      // With mem_en low the other port inputs are ignored.
      step("en_low", 1'b0, 1'b0, 1'b1, 32'h2C, 32'h7777_7777, 1'b0, 10'd0, 32'h0);
      rd("rd_word11", 32'h2C);

      // Reset during a read's valid cycle clears everything; array contents survive.
      rd("rd_pre_rst", 32'h8);
      step("rst_inflight", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 10'd0, 32'h0);
      rd("rd_post_rst", 32'h14);
      rd("rd_post_rst_wr", 32'h10);

      // A read registered at the same edge as rst is discarded.
      step("rd_with_rst", 1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 10'd0, 32'h0);
      idle("after_rd_rst");

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0; word-aligned.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port mem_en, input, 1, access request this cycle.
REQ-006 SHALL have port mem_we, input, 1, 1 = write, 0 = read; qualified by mem_en.
REQ-007 SHALL have port mem_addr, input, 32, byte address.
REQ-008 SHALL have port mem_wdata, input, 32, write data.
REQ-009 SHALL have port mem_rdata, output, 32, registered read data.
REQ-010 SHALL have port rdata_valid, output, 1, mem_rdata holds a fresh read result this cycle.
REQ-011 SHALL have port err_misaligned, output, 1, one-cycle pulse: previous-cycle access had mem_addr[1:0] != 0.
REQ-012 SHALL have port err_range, output, 1, one-cycle pulse: previous-cycle access fell outside [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS).
REQ-013 SHALL have port err_sticky, output, 1, OR of all error pulses since reset.
REQ-014 SHALL have port init_en, input, 1, backdoor word write for program/data preload.
REQ-015 SHALL have port init_idx, input, $clog2(DEPTH_WORDS), backdoor word index.
REQ-016 SHALL have port init_data, input, 32, backdoor write data.
REQ-017 SHALL have ports rd_count and wr_count, output, 32 each: completed in-range reads and writes.

Function
REQ-018 SHALL compute offset = mem_addr - ADDR_BASE (32-bit, wrapping) and word index = offset[$clog2(DEPTH_WORDS)+1:2].
REQ-019 SHALL treat an access as in range iff offset < 4*DEPTH_WORDS, compared unsigned; addresses below ADDR_BASE wrap to large offsets and are out of range.
REQ-020 SHALL register a read (mem_en=1, mem_we=0) at edge N and present the word on mem_rdata with rdata_valid=1 for exactly the cycle after edge N.
REQ-021 SHALL hold mem_rdata at its last value while rdata_valid=0; no read means no change.
REQ-022 SHALL, on a write (mem_en=1, mem_we=1), in range and aligned, update the array at the edge; rdata_valid stays 0 and mem_rdata is unchanged.
REQ-023 SHALL return the newly written value to a read issued in the cycle after a write to the same word; there is no stale window.
REQ-024 SHALL, on a misaligned in-range read, return the aligned containing word, pulse err_misaligned with rdata_valid, and count it in rd_count.
REQ-025 SHALL suppress a misaligned write entirely (array and wr_count unchanged) and pulse err_misaligned.
REQ-026 SHALL, on an out-of-range read, drive mem_rdata=0 with rdata_valid=1, pulse err_range, and leave rd_count unchanged; an out-of-range write is dropped and pulses err_range.
REQ-027 SHALL assert both err pulses in the same cycle when an access is both misaligned and out of range; range handling takes precedence for data and counts.
REQ-028 SHALL give init_en priority over a same-cycle mem write: the init write lands, the mem write is dropped, and no error is flagged; a same-cycle mem read proceeds and returns the pre-edge array value.
REQ-029 SHALL let rd_count and wr_count wrap modulo 2^32 without saturation.
REQ-030 SHALL ignore mem_we, mem_addr and mem_wdata when mem_en=0.

Reset
REQ-031 SHALL, when rst=1 at an edge, clear mem_rdata, rdata_valid, err_misaligned, err_range, err_sticky, rd_count and wr_count to 0.
REQ-032 SHALL leave array contents unchanged on reset; init_en writes remain honoured while rst=1.
REQ-033 SHALL discard a read registered in the same edge as rst=1, or in flight when rst rises: the next cycle shows rdata_valid=0 and mem_rdata=0.

Verification
REQ-034 Preload via init idx 5 = 32'hDEAD_BEEF, then read addr ADDR_BASE+20 -> next cycle mem_rdata=32'hDEAD_BEEF, rdata_valid=1, rd_count=1.
REQ-035 Write 32'h1234_5678 to addr 0x10, then read addr 0x10 on the following cycle -> mem_rdata=32'h1234_5678, wr_count=1, rd_count=1.
REQ-036 Write to 0x13 -> err_misaligned pulses 1 cycle, err_sticky=1, word 4 unchanged, wr_count=0; a read of 0x13 returns word 4.
REQ-037 Read addr 4*DEPTH_WORDS (4096 with defaults) -> mem_rdata=0, rdata_valid=1, err_range=1, rd_count unchanged.
REQ-038 Back-to-back reads of 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rdata_valid cycles with the matching words.
REQ-039 Assert rst in the cycle after a read issue -> rdata_valid=0, counters=0, err_sticky=0, and array contents still readable after reset.
